// File: rtl/spu_wb_stage.sv
// Writeback staging for the SPU even/odd pipes: latency-aligned delay lines feeding
// two register-file write ports, plus pending-write (busy) queries. Optional flush via SPU_WB_FLUSH_EN.
module spu_wb_stage #(
    parameter int DEPTH = 7,
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SPU_WB_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             even_valid,
    input  logic [LAT_W-1:0] even_lat,
    input  logic [6:0]       even_rt,
    input  logic [127:0]     even_data,
    input  logic             odd_valid,
    input  logic [LAT_W-1:0] odd_lat,
    input  logic [6:0]       odd_rt,
    input  logic [127:0]     odd_data,
    output logic             reg_write_en_1,
    output logic [6:0]       reg_write_addr_1,
    output logic [127:0]     reg_write_data_1,
    output logic             reg_write_en_2,
    output logic [6:0]       reg_write_addr_2,
    output logic [127:0]     reg_write_data_2,
    input  logic [6:0]       query_addr_1,
    input  logic [6:0]       query_addr_2,
    input  logic [6:0]       query_addr_3,
    input  logic [6:0]       query_addr_4,
    input  logic [6:0]       query_addr_5,
    input  logic [6:0]       query_addr_6,
    output logic             busy_1,
    output logic             busy_2,
    output logic             busy_3,
    output logic             busy_4,
    output logic             busy_5,
    output logic             busy_6,
    output logic             err
);

    // Index 0 is the even pipe, index 1 the odd pipe.
    logic             slot_v    [2][DEPTH];
    logic [6:0]       slot_rt   [2][DEPTH];
    logic [127:0]     slot_data [2][DEPTH];
    logic             next_v    [2][DEPTH];
    logic [6:0]       next_rt   [2][DEPTH];
    logic [127:0]     next_data [2][DEPTH];

    logic             in_valid [2];
    logic [LAT_W-1:0] in_lat   [2];
    logic [6:0]       in_rt    [2];
    logic [127:0]     in_data  [2];
    logic [6:0]       query    [6];
    logic [5:0]       busy_vec;
    logic             flush_now;
    logic             ins_err;

    assign in_valid[0] = even_valid;
    assign in_lat[0]   = even_lat;
    assign in_rt[0]    = even_rt;
    assign in_data[0]  = even_data;
    assign in_valid[1] = odd_valid;
    assign in_lat[1]   = odd_lat;
    assign in_rt[1]    = odd_rt;
    assign in_data[1]  = odd_data;

    assign query[0] = query_addr_1;
    assign query[1] = query_addr_2;
    assign query[2] = query_addr_3;
    assign query[3] = query_addr_4;
    assign query[4] = query_addr_5;
    assign query[5] = query_addr_6;

`ifdef SPU_WB_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Shift every slot one stage, then overlay the insert; a valid entry already
    // arriving in the target slot is overwritten and flagged.
    always_comb begin
        ins_err = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < DEPTH; s++) begin
                if (s == 0) begin
                    next_v[p][s]    = 1'b0;
                    next_rt[p][s]   = '0;
                    next_data[p][s] = '0;
                end else begin
                    next_v[p][s]    = slot_v[p][s-1];
                    next_rt[p][s]   = slot_rt[p][s-1];
                    next_data[p][s] = slot_data[p][s-1];
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (in_valid[p] && !flush_now) begin
                if (in_lat[p] == '0 || int'(in_lat[p]) > DEPTH) begin
                    ins_err = 1'b1;
                end else begin
                    for (int s = 0; s < DEPTH; s++) begin
                        if (s == DEPTH - int'(in_lat[p])) begin
                            if (next_v[p][s]) begin
                                ins_err = 1'b1;
                            end
                            next_v[p][s]    = 1'b1;
                            next_rt[p][s]   = in_rt[p];
                            next_data[p][s] = in_data[p];
                        end
                    end
                end
            end
        end
        // The final slot writes this cycle regardless, so clearing every next valid is enough.
        if (flush_now) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    next_v[p][s] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    slot_v[p][s]    <= 1'b0;
                    slot_rt[p][s]   <= '0;
                    slot_data[p][s] <= '0;
                end
            end
            err <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    slot_v[p][s]    <= next_v[p][s];
                    slot_rt[p][s]   <= next_rt[p][s];
                    slot_data[p][s] <= next_data[p][s];
                end
            end
            if (ins_err) begin
                err <= 1'b1;
            end
        end
    end

    assign reg_write_en_1   = slot_v[0][DEPTH-1];
    assign reg_write_addr_1 = slot_v[0][DEPTH-1] ? slot_rt[0][DEPTH-1]   : '0;
    assign reg_write_data_1 = slot_v[0][DEPTH-1] ? slot_data[0][DEPTH-1] : '0;
    assign reg_write_en_2   = slot_v[1][DEPTH-1];
    assign reg_write_addr_2 = slot_v[1][DEPTH-1] ? slot_rt[1][DEPTH-1]   : '0;
    assign reg_write_data_2 = slot_v[1][DEPTH-1] ? slot_data[1][DEPTH-1] : '0;

    // A query hits if any valid slot in either pipe, including the writing slot, targets it.
    always_comb begin
        busy_vec = '0;
        for (int k = 0; k < 6; k++) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (slot_v[p][s] && slot_rt[p][s] == query[k]) begin
                        busy_vec[k] = 1'b1;
                    end
                end
            end
        end
    end

    assign busy_1 = busy_vec[0];
    assign busy_2 = busy_vec[1];
    assign busy_3 = busy_vec[2];
    assign busy_4 = busy_vec[3];
    assign busy_5 = busy_vec[4];
    assign busy_6 = busy_vec[5];

endmodule
